// File: rtl/mrv_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for MINIRISC-V.
// Drives datapath enables and selects; counts retired instructions.
module mrv_seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             br_cond,
    input  logic             mem_ready,
    output logic [6:0]       alu_opcode,
    output logic [3:0]       alu_funct,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [1:0]       a_sel,
    output logic [1:0]       b_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic             ill_q;
    logic [CNT_W-1:0] cnt;

    logic [6:0] op;
    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_br;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       legal;
    logic       unused_bits;

    assign op         = instr[6:0];
    assign alu_opcode = op;
    assign alu_funct  = {instr[30], instr[14:12]};
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_r    = (op == 7'b0110011);
    assign is_i    = (op == 7'b0010011);
    assign is_lw   = (op == 7'b0000011);
    assign is_sw   = (op == 7'b0100011);
    assign is_br   = (op == 7'b1100011);
    assign is_jal  = (op == 7'b1101111);
    assign is_jalr = (op == 7'b1100111);
    assign is_lui  = (op == 7'b0110111);
    assign legal   = is_r | is_i | is_lw | is_sw
                   | is_br | is_jal | is_jalr | is_lui;

    always_comb begin
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        a_sel        = 2'b00;
        b_sel        = 2'b00;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        nxt          = state;
        if (rst) begin
            nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        nxt   = DECODE;
                    end
                end
                DECODE: nxt = legal ? EXEC : HALT;
                EXEC: begin
                    unique case (1'b1)
                        is_r: nxt = WB;
                        is_i, is_lw, is_sw, is_jalr: begin
                            b_sel = 2'b01;
                            nxt   = (is_lw | is_sw) ? MEM : WB;
                        end
                        is_lui: begin
                            a_sel = 2'b10;
                            b_sel = 2'b01;
                            nxt   = WB;
                        end
                        is_jal: nxt = WB;
                        is_br: begin
                            pc_we  = 1'b1;
                            pc_src = br_cond ? 2'b01 : 2'b00;
                            nxt    = FETCH;
                        end
                        default: nxt = HALT;
                    endcase
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_sw;
                    if (mem_ready) begin
                        pc_we = is_sw;
                        nxt   = is_sw ? FETCH : WB;
                    end
                end
                WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = FETCH;
                    unique case (1'b1)
                        is_lw: wb_sel = 2'b01;
                        is_jal: begin
                            wb_sel = 2'b10;
                            pc_src = 2'b01;
                        end
                        is_jalr: begin
                            wb_sel = 2'b10;
                            pc_src = 2'b10;
                        end
                        default: wb_sel = 2'b00;
                    endcase
                end
                HALT: nxt = HALT;
                default: nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cnt   <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= nxt;
            if (pc_we)
                cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (state == DECODE && !legal)
                ill_q <= 1'b1;
        end
    end

    // Debug/status outputs read as zero while reset is held.
    assign illegal = ill_q & ~rst;
    assign instret = rst ? '0 : cnt;
    assign state_o = rst ? FETCH : state;

endmodule
